// File: rtl/mux_scan_nto1.sv
// Registered N-channel, DW-bit multiplexer with direct-select and auto-scan modes.
// Outputs y/ch are sampled on the strobe edge; valid/wrap are one-cycle registered strobes.
module mux_scan_nto1 #(
  parameter int N_CH  = 16,
  parameter int DW    = 1,
  parameter int DWELL = 4,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 mode,
  input  logic [SEL_W-1:0]     sel,
  input  logic [N_CH*DW-1:0]   inp,
  output logic [DW-1:0]        y,
  output logic [SEL_W-1:0]     ch,
  output logic                 valid,
  output logic                 wrap
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(N_CH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] idx;

  logic [SEL_W-1:0] rd_addr;
  logic [DW-1:0]    rd_data;
  logic             rd_hit;

  // One read port shared by both modes; out-of-range addresses read as zero
  // and clear rd_hit so that direct mode can suppress valid.
  always_comb begin
    rd_addr = mode ? idx : sel;
    rd_data = '0;
    rd_hit  = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (rd_addr == SEL_W'(k)) begin
        rd_data = inp[k*DW +: DW];
        rd_hit  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      y     <= '0;
      ch    <= '0;
      valid <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      valid <= 1'b0;
      wrap  <= 1'b0;
      if (!en) begin
        state <= IDLE;
        cnt   <= '0;
      end else if (!mode) begin
        state <= DIRECT;
        cnt   <= '0;
        y     <= rd_data;
        ch    <= sel;
        valid <= rd_hit;
      end else if (state != SCAN) begin
        // Entry edge: restart the scan, sample nothing.
        state <= SCAN;
        cnt   <= '0;
        idx   <= '0;
      end else if (cnt == CNT_LAST) begin
        y     <= rd_data;
        ch    <= idx;
        valid <= 1'b1;
        wrap  <= (idx == IDX_LAST);
        cnt   <= '0;
        idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/mux_scan_nto1.md
Name: mux_scan_nto1

Overview:
- Parametrised, registered N-channel, DW-bit multiplexer; successor to the combinational 16:1 single-bit mux.
- Adds an enable, a registered output with valid strobe, and an auto-scan mode that steps through all channels with a programmable dwell.
- Sits between parallel status or sensor lines and a serial consumer: logging, scope probe, or UART formatter.

Parameters:
- N_CH, 16, number of input channels, 2..256, need not be a power of two.
- DW, 1, bits per channel.
- DWELL, 4, cycles per channel in scan mode, minimum 1.
- SEL_W, $clog2(N_CH), select and channel-index width (derived, do not override).

Ports:
- clk  in  1  single clock, all state rising-edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  block enable.
- mode  in  1  0 = direct select, 1 = auto-scan.
- sel  in  SEL_W  channel select, used in direct mode only.
- inp  in  N_CH*DW  packed inputs; channel k = inp[k*DW +: DW].
- y  out  DW  registered selected data.
- ch  out  SEL_W  channel index that y was sampled from.
- valid  out  1  y/ch updated this cycle.
- wrap  out  1  scan completed the last channel.

Behaviour:
- Reset, asynchronous: y=0, ch=0, valid=0, wrap=0, dwell counter=0, state=IDLE. Applies mid-operation with no partial update.
- States: IDLE, DIRECT, SCAN. The state is re-evaluated every cycle from en and mode:
  - en=0 → IDLE
  - en=1, mode=0 → DIRECT
  - en=1, mode=1 → SCAN
- IDLE:
  - y and ch hold their last values.
  - valid=0, wrap=0.
  - Dwell counter cleared.
- DIRECT:
  - Each cycle samples y ← channel sel, ch ← sel, valid=1. Latency 1 cycle from sel/inp to y.
  - sel ≥ N_CH (out of range): y ← 0, ch ← sel, valid=0.
  - wrap=0 always.
- SCAN entry (previous state not SCAN):
  - ch index reset to 0, dwell counter reset to 0.
  - Nothing sampled on the entry cycle.
- SCAN steady state:
  - Dwell counter increments each cycle.
  - When the counter = DWELL-1: y ← channel at the current scan index, ch ← that index, valid=1 for that cycle. The counter then returns to 0 and the index advances.
  - Index N_CH-1 wraps to 0. wrap=1 in the same cycle as the valid for channel N_CH-1.
- Throughput:
  - DWELL=1: one sample per cycle, first valid on the cycle after entry.
  - General case: first valid DWELL cycles after entry; one valid per DWELL cycles.
- Mode switching:
  - SCAN → DIRECT takes effect the next edge. The scan index is discarded; re-entering SCAN restarts at channel 0.
  - Dropping en mid-dwell discards the partial dwell.
- valid and wrap are single-cycle strobes, registered, never combinational from inputs.
- inp is treated as synchronous to clk; no internal synchronisers.

Test Plan:
- Reset: assert rst asynchronously mid-cycle during SCAN → y=0, ch=0, valid=0, wrap=0 immediately. After release with en=0 → outputs stay 0.
- Direct sweep (N_CH=16, DW=1): en=1, mode=0, one-hot inp with bit i set and sel=i for i=0..15 → one cycle later y=1, ch=i, valid=1 for each i. Also drive sel=i with inp bit (i+1)%16 set → y=0.
- Out-of-range (N_CH=10, DW=4): sel=12 → y=0, valid=0. sel=9 with inp[39:36]=4'hA → y=4'hA, valid=1.
- Scan timing (N_CH=4, DW=8, DWELL=3): inp={8'h44,8'h33,8'h22,8'h11}, en=1, mode=1 → valid on cycles 3, 6, 9, 12 after entry. y sequence 11, 22, 33, 44 with ch 0..3. wrap=1 only on the cycle-12 strobe, then the sequence repeats.
- DWELL=1, N_CH=16: scan → valid continuously from the cycle after entry, ch increments every cycle, wrap every 16th cycle.
- Mode/enable interruption: during scan at ch=2, mid-dwell, drop en for 2 cycles then restore → no valid while en=0; scan restarts at ch=0 with a full DWELL. Switching to mode=0 with sel=5 → next cycle ch=5, valid=1.
